// File: rtl/serial_mod_checker.sv
// Bit-serial divisibility checker: keeps a running remainder modulo DIVISOR
// for an MSB-first or LSB-first framed number, with a pulsed per-number result.
module serial_mod_checker #(
  parameter  int DIVISOR = 5,
  parameter  int CNT_W   = 16,
  localparam int RW      = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din_start,
  input  logic             din_last,
  input  logic             din,
  input  logic             msb_first,
  output logic             dout,
  output logic [RW-1:0]    remainder,
  output logic [CNT_W-1:0] nbits,
  output logic             result_valid,
  output logic             result_div
);

  generate
    if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
      $error("serial_mod_checker: DIVISOR must be in 2..65535");
    end
  endgenerate

  localparam logic [RW:0] DIV_C = DIVISOR[RW:0];

  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    wgt_q, wgt_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             rvalid_q;
  logic             rdiv_q;

  logic [RW-1:0] base_rem, base_wgt;
  logic [RW:0]   t_msb, t_lsb, t_wgt;
  logic [RW:0]   r_msb, r_lsb, r_wgt;

  // Every intermediate is below 2*DIVISOR, so one conditional subtract
  // brings it back into range.
  always_comb begin
    base_rem = din_start ? '0 : rem_q;
    base_wgt = din_start ? RW'(1) : wgt_q;
    mode_d   = din_start ? msb_first : mode_q;

    t_msb = {base_rem, din};
    t_lsb = {1'b0, base_rem} + (din ? {1'b0, base_wgt} : '0);
    t_wgt = {base_wgt, 1'b0};

    r_msb = (t_msb >= DIV_C) ? (t_msb - DIV_C) : t_msb;
    r_lsb = (t_lsb >= DIV_C) ? (t_lsb - DIV_C) : t_lsb;
    r_wgt = (t_wgt >= DIV_C) ? (t_wgt - DIV_C) : t_wgt;

    rem_d = mode_d ? r_msb[RW-1:0] : r_lsb[RW-1:0];
    wgt_d = mode_d ? base_wgt : r_wgt[RW-1:0];

    if (din_start)
      nbits_d = CNT_W'(1);
    else if (&nbits_q)
      nbits_d = nbits_q;
    else
      nbits_d = nbits_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      wgt_q    <= RW'(1);
      mode_q   <= 1'b1;
      nbits_q  <= '0;
      rvalid_q <= 1'b0;
      rdiv_q   <= 1'b1;
    end else begin
      rvalid_q <= din_valid && din_last;
      if (din_valid) begin
        rem_q   <= rem_d;
        wgt_q   <= wgt_d;
        mode_q  <= mode_d;
        nbits_q <= nbits_d;
        if (din_last)
          rdiv_q <= (rem_d == '0);
      end
    end
  end

  assign dout         = (rem_q == '0);
  assign remainder    = rem_q;
  assign nbits        = nbits_q;
  assign result_valid = rvalid_q;
  assign result_div   = rdiv_q;

endmodule
